// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, registered sync/blank decode and delayed copies; FRAME_CNT_EN adds frame_cnt
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       blank_d,
  output logic       hs_d,
  output logic       vs_d
`ifdef FRAME_CNT_EN
  , output logic [15:0] frame_cnt
`endif
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_chk_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 10-bit counters");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_chk_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..4");
  end

  logic [9:0] nx, ny;
  logic       h_wrap;

  // Next raster position; decode uses it so flags line up with the counters they accompany
  always_comb begin
    h_wrap = DrawX == H_LAST;
    nx = h_wrap ? '0 : DrawX + 10'd1;
    ny = h_wrap ? (DrawY == V_LAST ? '0 : DrawY + 10'd1) : DrawY;
  end

  // Counters and registered decode; reset parks on the last pixel so the first edge lands on (0,0)
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= nx;
      DrawY       <= ny;
      blank       <= nx < H_VIS && ny < V_VIS;
      hs          <= !(nx >= HS_ON && nx < HS_OFF);
      vs          <= !(ny >= VS_ON && ny < VS_OFF);
      frame_start <= nx == '0 && ny == '0;
    end

  if (PIPE_DLY == 0) begin : g_pass
    assign {blank_d, hs_d, vs_d} = {blank, hs, vs};
  end else begin : g_dly
    logic [2:0] pipe [PIPE_DLY];
    // Shift {blank,hs,vs} to match the renderers' colour latency; idle pattern on reset
    always_ff @(posedge vga_clk or posedge reset)
      if (reset) begin
        for (int i = 0; i < PIPE_DLY; i++) pipe[i] <= 3'b011;
      end else begin
        pipe[0] <= {blank, hs, vs};
        for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];
      end
    assign {blank_d, hs_d, vs_d} = pipe[PIPE_DLY-1];
  end

`ifdef FRAME_CNT_EN
  // Frame counter bumps on the edge that raises frame_start
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) frame_cnt <= '0;
    else if (nx == '0 && ny == '0) frame_cnt <= frame_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a full-size and a reduced-size raster (FRAME_CNT_EN optional)
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] x, y, sx, sy;
  logic blank, hs, vs, fs, blank_d, hs_d, vs_d;
  logic sblank, shs, svs, sfs, sblank_d, shs_d, svs_d;
`ifdef FRAME_CNT_EN
  logic [15:0] fc, sfc;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .vga_clk(clk), .reset(rst), .DrawX(x), .DrawY(y), .blank(blank), .hs(hs), .vs(vs),
    .frame_start(fs), .blank_d(blank_d), .hs_d(hs_d), .vs_d(vs_d)
`ifdef FRAME_CNT_EN
    , .frame_cnt(fc)
`endif
  );

  // 16 x 11 raster: hs low X 10..12, vs low Y 7..8, frame 176 cycles, no delay
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DLY(0)
  ) sm (
    .vga_clk(clk), .reset(rst), .DrawX(sx), .DrawY(sy), .blank(sblank), .hs(shs), .vs(svs),
    .frame_start(sfs), .blank_d(sblank_d), .hs_d(shs_d), .vs_d(svs_d)
`ifdef FRAME_CNT_EN
    , .frame_cnt(sfc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    logic [2:0] hist [800];
    logic [2:0] want;
    int nb, nh, nv, nf, bfirst, hfirst, hlast, vfirst, vlast, dmis, xmis, f2;
    #12;
    chk("rst_x", x, 799); chk("rst_y", y, 524);
    chk("rst_blank", blank, 0); chk("rst_hs", hs, 1); chk("rst_vs", vs, 1); chk("rst_fs", fs, 0);
    chk("rst_d", {blank_d, hs_d, vs_d}, 3'b011);
    chk("rst_sx", sx, 15); chk("rst_sy", sy, 10);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("first_x", x, 0); chk("first_y", y, 0); chk("first_blank", blank, 1);
    chk("first_fs", fs, 1); chk("first_hs", hs, 1); chk("first_vs", vs, 1);
    chk("first_d", {blank_d, hs_d, vs_d}, 3'b011);
    chk("first_sxy", {sx, sy}, 0); chk("first_sfs", sfs, 1);
    nb = 0; nh = 0; nv = 0; nf = 0; bfirst = -1; hfirst = -1; hlast = -1; dmis = 0; xmis = 0;
    for (int i = 0; i < 800; i++) begin
      if (x !== 10'(i) || y !== 10'd0) xmis++;
      hist[i] = {blank, hs, vs};
      want = (i < 2) ? 3'b011 : hist[i-2];
      if ({blank_d, hs_d, vs_d} !== want) dmis++;
      nb += int'(blank);
      if (!blank && bfirst < 0) bfirst = i;
      if (!hs) begin nh++; if (hfirst < 0) hfirst = i; hlast = i; end
      nv += int'(!vs);
      nf += int'(fs);
      @(negedge clk);
    end
    chk("line_xy", xmis, 0); chk("blank_cnt", nb, 640); chk("blank_fall", bfirst, 640);
    chk("hs_cnt", nh, 96); chk("hs_start", hfirst, 656); chk("hs_end", hlast, 751);
    chk("vs_line0", nv, 0); chk("fs_line0", nf, 1); chk("dly2_align", dmis, 0);
    chk("line_wrap_x", x, 0); chk("line_wrap_y", y, 1);
    repeat (1100) @(negedge clk);
    chk("pre_rst_x", x, 300); chk("pre_rst_y", y, 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_x", x, 799); chk("mid_rst_y", y, 524); chk("mid_rst_blank", blank, 0);
    chk("mid_rst_hsvs", {hs, vs, fs}, 3'b110); chk("mid_rst_d", {blank_d, hs_d, vs_d}, 3'b011);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rel_xy", {x, y}, 0); chk("rel_blank", blank, 1);
    repeat (700) @(negedge clk);
    chk("hs_mid_x", x, 700); chk("hs_mid", hs, 0); chk("hs_d_mid", hs_d, 0);
    #2 rst = 1'b1;
    #1;
    chk("hs_rst", hs, 1); chk("hs_d_rst", hs_d, 1); chk("hs_rst_x", x, 799);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    nv = 0; nf = 0; vfirst = -1; vlast = -1; dmis = 0; f2 = -1;
    for (int c = 0; c <= 352; c++) begin
      if ({sblank_d, shs_d, svs_d} !== {sblank, shs, svs}) dmis++;
      if (sfs) begin nf++; if (c > 0 && f2 < 0) f2 = c; end
      if (!svs && c < 176) begin nv++; if (vfirst < 0) vfirst = c; vlast = c; end
      if (c == 9) chk("s_hs9", shs, 1);
      if (c == 10) chk("s_hs10", shs, 0);
      if (c == 13) chk("s_hs13", shs, 1);
      if (c == 87) begin chk("s_xy87", {sx, sy}, {10'd7, 10'd5}); chk("s_blank87", sblank, 1); end
      if (c == 88) begin chk("s_x88", sx, 8); chk("s_blank88", sblank, 0); end
      if (c == 96) begin chk("s_y96", sy, 6); chk("s_blank96", sblank, 0); end
      if (c == 175) chk("s_xy175", {sx, sy}, {10'd15, 10'd10});
      if (c == 176) begin chk("s_xy176", {sx, sy}, 0); chk("s_blank176", sblank, 1); end
`ifdef FRAME_CNT_EN
      if (c == 0) chk("fcnt_1", sfc, 1);
      if (c == 352) chk("fcnt_3", sfc, 3);
`endif
      @(negedge clk);
    end
    chk("s_fs_cnt", nf, 3); chk("s_fs_period", f2, 176); chk("s_vs_cnt", nv, 32);
    chk("s_vs_start", vfirst, 112); chk("s_vs_end", vlast, 143); chk("dly0_align", dmis, 0);
    repeat (111) @(negedge clk);
    chk("s_vs_y", sy, 7); chk("s_vs_low", svs, 0); chk("s_vs_d_low", svs_d, 0);
    #2 rst = 1'b1;
    #1;
    chk("s_vs_rst", svs, 1); chk("s_vs_d_rst", svs_d, 1); chk("s_rst_xy", {sx, sy}, {10'd15, 10'd10});
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
`ifdef FRAME_CNT_EN
    chk("fcnt_rel", sfc, 1);
    force sm.frame_cnt = 16'hFFFF;
    #1 release sm.frame_cnt;
    chk("fcnt_forced", sfc, 65535);
    repeat (176) @(negedge clk);
    chk("fcnt_wrap_fs", sfs, 1);
    chk("fcnt_wrap", sfc, 0);
`endif
    chk("end_sxy", {sx, sy}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
